// File: rtl/ro_sweep_sequencer_zeptobars.sv
// Ring-oscillator sweep sequencer: loads the 12-bit stage-config chain once, then for each
// oscillator source settles, gates a fixed window of clk and reports the synchronised edge count.
module ro_sweep_sequencer_zeptobars #(
    parameter int SHIFT_HALF    = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int GATE_CYCLES   = 1024,
    parameter int CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [11:0]      i_cfg_word,
    input  logic [2:0]       i_src_first,
    input  logic [2:0]       i_src_last,
    input  logic             i_osc_in,
    output logic             o_shift_clk,
    output logic             o_shift_dta,
    output logic [2:0]       o_clk_source,
    output logic             o_osc_rst,
    output logic             o_busy,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic [2:0]       o_result_src,
    output logic [CNT_W-1:0] o_result_count,
    output logic             o_sweep_done,
    output logic [2:0]       o_dbg_state
);

    // Result handshake: a result transfers on a clk edge where o_result_valid and
    // i_result_ready are both high; valid/src/count stay constant until then.

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_GATE   = 3'd3,
        ST_REPORT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int PH_W    = $clog2(SHIFT_HALF + 1);
    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t           r_state;
    logic [11:0]      r_sh;
    logic [3:0]       r_bit;
    logic [PH_W-1:0]  r_ph;
    logic [TMR_W-1:0] r_tmr;
    logic [2:0]       r_src_last;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_count;
    logic             r_shift_clk;
    logic             r_shift_dta;
    logic [2:0]       r_clk_source;
    logic             r_osc_rst;
    logic             r_busy;
    logic             r_result_valid;
    logic [2:0]       r_result_src;
    logic             r_sweep_done;

    logic             w_rise;
    logic [CNT_W-1:0] w_count_next;

    assign w_rise       = r_sync2 & ~r_prev;
    assign w_count_next = (w_rise && (r_count != {CNT_W{1'b1}})) ? r_count + CNT_W'(1) : r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_sh           <= '0;
            r_bit          <= '0;
            r_ph           <= '0;
            r_tmr          <= '0;
            r_src_last     <= '0;
            r_sync1        <= 1'b0;
            r_sync2        <= 1'b0;
            r_prev         <= 1'b0;
            r_count        <= '0;
            r_shift_clk    <= 1'b0;
            r_shift_dta    <= 1'b0;
            r_clk_source   <= '0;
            r_osc_rst      <= 1'b1;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_src   <= '0;
            r_sweep_done   <= 1'b0;
        end else begin
            r_sync1      <= i_osc_in;
            r_sync2      <= r_sync1;
            r_sweep_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_osc_rst <= 1'b1;
                    if (i_start) begin
                        r_sh         <= i_cfg_word;
                        r_shift_dta  <= i_cfg_word[11];
                        r_shift_clk  <= 1'b0;
                        r_bit        <= '0;
                        r_ph         <= '0;
                        r_clk_source <= i_src_first;
                        r_src_last   <= i_src_last;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The shift_clk level doubles as the low/high phase marker.
                    if (r_ph == PH_W'(SHIFT_HALF - 1)) begin
                        r_ph <= '0;
                        if (!r_shift_clk) begin
                            r_shift_clk <= 1'b1;
                        end else begin
                            r_shift_clk <= 1'b0;
                            if (r_bit == 4'd11) begin
                                r_shift_dta <= 1'b0;
                                r_tmr       <= '0;
                                r_state     <= ST_SETTLE;
                            end else begin
                                r_bit       <= r_bit + 4'd1;
                                r_sh        <= {r_sh[10:0], 1'b0};
                                r_shift_dta <= r_sh[10];
                            end
                        end
                    end else begin
                        r_ph <= r_ph + PH_W'(1);
                    end
                end
                ST_SETTLE: begin
                    r_osc_rst <= 1'b1;
                    if (r_tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                        r_tmr     <= '0;
                        r_osc_rst <= 1'b0;
                        r_count   <= '0;
                        r_prev    <= r_sync2;
                        r_state   <= ST_GATE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_GATE: begin
                    r_count <= w_count_next;
                    r_prev  <= r_sync2;
                    if (r_tmr == TMR_W'(GATE_CYCLES - 1)) begin
                        r_tmr          <= '0;
                        r_osc_rst      <= 1'b1;
                        r_result_valid <= 1'b1;
                        r_result_src   <= r_clk_source;
                        r_state        <= ST_REPORT;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_REPORT: begin
                    r_osc_rst <= 1'b1;
                    if (i_result_ready) begin
                        r_result_valid <= 1'b0;
                        if (r_clk_source == r_src_last) begin
                            r_sweep_done <= 1'b1;
                            r_state      <= ST_DONE;
                        end else begin
                            r_clk_source <= r_clk_source + 3'd1;
                            r_tmr        <= '0;
                            r_state      <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_shift_clk    = r_shift_clk;
    assign o_shift_dta    = r_shift_dta;
    assign o_clk_source   = r_clk_source;
    assign o_osc_rst      = r_osc_rst;
    assign o_busy         = r_busy;
    assign o_result_valid = r_result_valid;
    assign o_result_src   = r_result_src;
    assign o_result_count = r_count;
    assign o_sweep_done   = r_sweep_done;
    assign o_dbg_state    = r_state;

endmodule
